// File: rtl/serial_paralelo_alineado.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Runs on the bit clock, hunts for COMMA at any bit offset in the MSB-first
// stream, then locks word boundaries to it. The link is declared active after
// LOCK_COUNT aligned commas in a row, and lock is dropped after UNLOCK_COUNT
// misaligned commas in a row.
module serial_paralelo_alineado #(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   COMMA        = WIDTH'(8'hBC),
    parameter int                 LOCK_COUNT   = 4,
    parameter int                 UNLOCK_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data2send,
    output logic             word_strobe,
    output logic             active,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam int UCW = $clog2(UNLOCK_COUNT + 1);
    localparam int BCW = $clog2(WIDTH);

    localparam logic [BCW-1:0] BIT_LAST    = BCW'(WIDTH - 1);
    localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_COUNT - 1);
    localparam logic [UCW-1:0] UNLOCK_LAST = UCW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-2:0] sr_reg;
    logic [BCW-1:0]   bit_cnt_reg;
    logic [LCW-1:0]   lock_cnt_reg;
    logic [UCW-1:0]   mis_cnt_reg;
    logic [WIDTH-1:0] data2send_reg;
    logic             word_strobe_reg;
    logic             active_reg;
    logic             valid_out_reg;
    logic [WIDTH-1:0] data_out_reg;

    logic [WIDTH-1:0] w;
    logic             is_comma;
    logic             boundary;

    // Candidate word including the bit being sampled on this edge.
    assign w        = {sr_reg, data_in};
    assign is_comma = (w == COMMA);

    // While searching, any comma defines a boundary; otherwise the bit counter does.
    always_comb begin
        boundary = 1'b0;
        if (state_reg == SEARCH) begin
            boundary = is_comma;
        end else begin
            boundary = (bit_cnt_reg == BIT_LAST);
        end
    end

    // Shift register, bit counter, alignment FSM and all registered outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_reg       <= SEARCH;
            sr_reg          <= '0;
            bit_cnt_reg     <= '0;
            lock_cnt_reg    <= '0;
            mis_cnt_reg     <= '0;
            data2send_reg   <= '0;
            word_strobe_reg <= 1'b0;
            active_reg      <= 1'b0;
            valid_out_reg   <= 1'b0;
            data_out_reg    <= '0;
        end else begin
            sr_reg          <= w[WIDTH-2:0];
            word_strobe_reg <= boundary;
            if (boundary) begin
                data2send_reg <= w;
            end

            // A comma seen in SEARCH restarts the word phase; otherwise wrap.
            if ((state_reg == SEARCH && is_comma) || bit_cnt_reg == BIT_LAST) begin
                bit_cnt_reg <= '0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            case (state_reg)
                SEARCH: begin
                    if (is_comma) begin
                        lock_cnt_reg <= LCW'(1);
                        mis_cnt_reg  <= '0;
                        if (LOCK_COUNT == 1) begin
                            state_reg  <= ACTIVE;
                            active_reg <= 1'b1;
                        end else begin
                            state_reg <= COUNT;
                        end
                    end
                end

                COUNT: begin
                    if (boundary) begin
                        if (is_comma) begin
                            // Count is always below LOCK_COUNT here, so no wrap.
                            lock_cnt_reg <= lock_cnt_reg + 1'b1;
                            if (lock_cnt_reg == LOCK_LAST) begin
                                state_reg  <= ACTIVE;
                                active_reg <= 1'b1;
                            end
                        end else begin
                            state_reg    <= SEARCH;
                            lock_cnt_reg <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    if (boundary) begin
                        if (is_comma) begin
                            valid_out_reg <= 1'b0;
                            mis_cnt_reg   <= '0;
                        end else begin
                            data_out_reg  <= w;
                            valid_out_reg <= 1'b1;
                        end
                    end else if (is_comma) begin
                        if (mis_cnt_reg == UNLOCK_LAST) begin
                            state_reg     <= SEARCH;
                            active_reg    <= 1'b0;
                            valid_out_reg <= 1'b0;
                            data_out_reg  <= '0;
                            lock_cnt_reg  <= '0;
                            mis_cnt_reg   <= '0;
                            bit_cnt_reg   <= '0;
                        end else begin
                            mis_cnt_reg <= mis_cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= SEARCH;
                end
            endcase
        end
    end

    assign data2send   = data2send_reg;
    assign word_strobe = word_strobe_reg;
    assign active      = active_reg;
    assign valid_out   = valid_out_reg;
    assign data_out    = data_out_reg;

endmodule

// File: doc/serial_paralelo_alineado.md
Name: serial_paralelo_alineado

Overview:
Parametrised serial-to-parallel receiver with comma-based word alignment. It runs on the bit clock, searches the incoming MSB-first stream for the COMMA pattern at any bit offset, and locks word boundaries to it. It declares the link active after LOCK_COUNT consecutive aligned commas, and drops lock after UNLOCK_COUNT consecutive misaligned commas. It sits between the serialiser and the byte-level receive logic of the physical layer, and replaces the fixed-phase 8-bit converter.

Parameters:
WIDTH, 8, word width in bits (>=4)
COMMA, 8'hBC, WIDTH-bit alignment/idle pattern
LOCK_COUNT, 4, consecutive aligned commas needed to assert active (>=1)
UNLOCK_COUNT, 4, consecutive misaligned commas that drop lock (>=1)

Ports:
clk_32f  input  1  bit clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial bit, MSB first
data2send  output  WIDTH  last word assembled at a boundary (raw, includes commas)
word_strobe  output  1  one-cycle pulse, high the cycle after data2send updates
active  output  1  link locked
valid_out  output  1  data_out holds a non-comma payload word
data_out  output  WIDTH  payload word, updated only while active

Behaviour:
- Clocking and reset: one clock, clk_32f. reset is asynchronous and active-low. While reset==0: all outputs 0, state=SEARCH, all counters 0, shift register 0.
- Candidate word each edge: w = {sr[WIDTH-2:0], data_in}. The shift register updates every edge as sr <= w.
- bit_cnt is 0..WIDTH-1 and wraps. A boundary edge is one where bit_cnt==WIDTH-1, or the matching edge in SEARCH.
- At every boundary edge: data2send <= w and word_strobe <= 1. On all other edges word_strobe <= 0.
- SEARCH:
  - bit_cnt is ignored.
  - On any edge with w==COMMA: bit_cnt <= 0, aligned-comma count <= 1, that edge counts as a boundary.
  - If LOCK_COUNT==1, go directly to ACTIVE with active <= 1. Otherwise go to COUNT.
  - No match: stay in SEARCH.
- COUNT (boundary edges only):
  - w==COMMA: count++. When count reaches LOCK_COUNT, go to ACTIVE with active <= 1 on that same edge.
  - w!=COMMA: go to SEARCH, count <= 0.
  - valid_out=0 and data_out=0 throughout.
- ACTIVE:
  - Boundary edge, w==COMMA: valid_out <= 0, data_out holds its value, misaligned count <= 0.
  - Boundary edge, w!=COMMA: data_out <= w, valid_out <= 1.
  - Non-boundary edge, w==COMMA: misaligned count++. On reaching UNLOCK_COUNT: go to SEARCH, active <= 0, valid_out <= 0, data_out <= 0, counters cleared, all on that edge.
  - A misaligned comma and a boundary cannot occur on the same edge; a boundary takes precedence.
- Latency: data2send, data_out and valid_out change on the edge that samples the word's LSB, i.e. visible 1 cycle after the last bit is presented.
- Counter widths: $clog2(LOCK_COUNT+1) and $clog2(UNLOCK_COUNT+1). Counters saturate and never wrap.
- Reset asserted mid-word: immediate return to reset state. After release, alignment restarts from SEARCH.
- Data words equal to COMMA are indistinguishable from idle and are never flagged valid.

Test Plan:
1. Lock at offset 3: reset low 5 cycles, then 3 random bits, 4×0xBC, then 0x5A. Required: active rises on the LSB edge of the 4th comma. data_out=0x5A with valid_out=1 one word later. word_strobe pulses every 8 cycles after the first match.
2. Broken lock attempt: 2×0xBC, 0x33, then 4×0xBC, 0xA5. Required: return to SEARCH on 0x33 with active staying 0. Re-lock and output data_out=0xA5 with valid_out=1.
3. Idle while active: after lock, send 0x11, 0xBC, 0x22. Required: valid_out 1,0,1. data_out 0x11, 0x11 (held), 0x22.
4. Loss of lock: after lock, insert 1 stray bit, then 4×0xBC. Required: active falls on the 4th misaligned comma edge with data_out=0. Subsequent commas re-lock at the new phase after 4 aligned commas.
5. Async reset mid-word: assert reset on bit 5 of a payload word while active, between clock edges. Required: all outputs 0 immediately, without waiting for a clock edge. After release, no valid_out until a full re-lock.
6. Parameter sweep: WIDTH=10, COMMA=10'h17C, LOCK_COUNT=2, UNLOCK_COUNT=1. Required: active after 2 aligned commas. A single misaligned comma drops lock.
